bp_upd_sched: RTL and testbench

Schedules resolved-branch updates into the single-ported branch predictor tables (BTB/PHT) in stage1. Execute-stage updates are buffered in a small FIFO. The block arbitrates the shared table port between fetch lookups and queued writes. Lookups win by default. Writes are forced on a mispredict, a full queue, or lookup starvation of the write path.

---
 rtl/bp_upd_sched_if.sv | 38 +++
 rtl/bp_upd_sched.sv | 140 ++++++++++++++
 tb/tb_bp_upd_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_upd_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : bp_upd_sched_if
// Brief   : Fetch-lookup / branch-update / table-write bundle for bp_upd_sched.
// Rev     : 1.0  initial release
// ============================================================================
interface bp_upd_sched_if #(
    parameter int BP_SIZE = 11,
    parameter int Q_DEPTH = 4
);
    logic                       lookup_req;
    logic                       lookup_gnt;
    logic                       upd_valid;
    logic                       upd_ready;
    logic [63:0]                upd_pc;
    logic [63:0]                upd_target;
    logic                       upd_taken;
    logic                       upd_mispred;
    logic                       tbl_we;
    logic [BP_SIZE-1:0]         tbl_idx;
    logic [63:0]                tbl_pc;
    logic [63:0]                tbl_target;
    logic                       tbl_taken;
    logic [$clog2(Q_DEPTH):0]   q_cnt;

    modport master (
        output lookup_req, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        input  lookup_gnt, upd_ready, tbl_we, tbl_idx, tbl_pc, tbl_target,
               tbl_taken, q_cnt
    );

    modport slave (
        input  lookup_req, upd_valid, upd_pc, upd_target, upd_taken, upd_mispred,
        output lookup_gnt, upd_ready, tbl_we, tbl_idx, tbl_pc, tbl_target,
               tbl_taken, q_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bp_upd_sched.sv
`default_nettype none
// ============================================================================
// Module  : bp_upd_sched
// Brief   : Queues resolved-branch updates and arbitrates the single BTB/PHT
//           port between fetch lookups and table writes.
//           Option macro: BP_UPD_COALESCE_EN (merge same-PC updates at tail).
// Rev     : 1.0  initial release
// ============================================================================
module bp_upd_sched #(
    parameter int BP_SIZE    = 11,
    parameter int Q_DEPTH    = 4,
    parameter int STARVE_MAX = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bp_upd_sched_if.slave   bus
);
    localparam int c_PTR_W = $clog2(Q_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(Q_DEPTH);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PEND  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [63:0]          r_pc  [Q_DEPTH];
    logic [63:0]          r_tgt [Q_DEPTH];
    logic [Q_DEPTH-1:0]   r_tkn;
    logic [Q_DEPTH-1:0]   r_msp;
    logic [Q_DEPTH-1:0]   w_msp_nxt;
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   w_tail;
    logic [c_PTR_W-1:0]   w_rd_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_STV_W-1:0]   r_stv;
    logic [c_STV_W-1:0]   w_stv_nxt;
    logic                 w_full;
    logic                 w_we;
    logic                 w_rdy;
    logic                 w_alloc;
    logic                 w_coal;
`ifdef BP_UPD_COALESCE_EN
    logic                 w_coal_ok;
`endif

    always_comb begin
        w_full = (r_cnt == c_FULL);
        w_we   = !rst && ((r_state == S_FORCE) ||
                          ((r_state == S_PEND) && !bus.lookup_req));
        w_tail = r_wr - c_PTR_W'(1);
`ifdef BP_UPD_COALESCE_EN
        // Tail merge is only safe while that entry is not leaving this cycle.
        w_coal_ok = (r_cnt != '0) && (bus.upd_pc == r_pc[w_tail]) &&
                    !(w_we && (r_cnt == c_CNT_W'(1)));
        w_rdy     = !rst && (!w_full || w_coal_ok);
        w_coal    = bus.upd_valid && w_rdy && w_coal_ok;
        w_alloc   = bus.upd_valid && w_rdy && !w_coal_ok;
`else
        w_rdy     = !rst && !w_full;
        w_coal    = 1'b0;
        w_alloc   = bus.upd_valid && w_rdy;
`endif
        w_cnt_nxt = r_cnt + c_CNT_W'(w_alloc) - c_CNT_W'(w_we);
        w_rd_nxt  = r_rd + c_PTR_W'(w_we);

        w_msp_nxt = r_msp;
        if (w_alloc) begin
            w_msp_nxt[r_wr] = bus.upd_mispred;
        end
        if (w_coal) begin
            w_msp_nxt[w_tail] = r_msp[w_tail] | bus.upd_mispred;
        end

        if ((r_cnt != '0) && !w_we) begin
            w_stv_nxt = (r_stv == c_STV_MAX) ? r_stv : r_stv + c_STV_W'(1);
        end else begin
            w_stv_nxt = '0;
        end

        // Next state looks at the queue as it will be after this edge.
        if (w_cnt_nxt == '0) begin
            w_state_nxt = S_EMPTY;
        end else if (w_msp_nxt[w_rd_nxt] || (w_cnt_nxt == c_FULL) ||
                     (w_stv_nxt == c_STV_MAX)) begin
            w_state_nxt = S_FORCE;
        end else begin
            w_state_nxt = S_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_tgt[i] <= '0;
            end
            r_tkn   <= '0;
            r_msp   <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_stv   <= '0;
            r_state <= S_EMPTY;
        end else begin
            if (w_alloc) begin
                r_pc[r_wr]  <= bus.upd_pc;
                r_tgt[r_wr] <= bus.upd_target;
                r_tkn[r_wr] <= bus.upd_taken;
                r_wr        <= r_wr + c_PTR_W'(1);
            end
            if (w_coal) begin
                r_tgt[w_tail] <= bus.upd_target;
                r_tkn[w_tail] <= bus.upd_taken;
            end
            r_msp   <= w_msp_nxt;
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stv   <= w_stv_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign bus.tbl_we     = w_we;
    assign bus.lookup_gnt = !rst && bus.lookup_req && !w_we;
    assign bus.upd_ready  = w_rdy;
    assign bus.tbl_pc     = rst ? '0   : r_pc[r_rd];
    assign bus.tbl_idx    = rst ? '0   : r_pc[r_rd][BP_SIZE+1:2];
    assign bus.tbl_target = rst ? '0   : r_tgt[r_rd];
    assign bus.tbl_taken  = rst ? 1'b0 : r_tkn[r_rd];
    assign bus.q_cnt      = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_bp_upd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_upd_sched
// Brief   : Directed stimulus with a write-order scoreboard for bp_upd_sched.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bp_upd_sched;
    localparam int BP_SIZE    = 11;
    localparam int Q_DEPTH    = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_upd_sched_if #(.BP_SIZE(BP_SIZE), .Q_DEPTH(Q_DEPTH)) bus ();

    bp_upd_sched #(
        .BP_SIZE    (BP_SIZE),
        .Q_DEPTH    (Q_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        tkn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   nwr   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds upd_valid until accepted; the expected write is recorded on acceptance.
    task automatic send(input logic [63:0] pc, input logic [63:0] tgt,
                        input logic tkn, input logic msp, input logic coal,
                        output int refused, output int acc_cnt);
        bit   done;
        exp_t e;
        done    = 1'b0;
        refused = 0;
        acc_cnt = -1;
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_target  = tgt;
        bus.upd_taken   = tkn;
        bus.upd_mispred = msp;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.upd_ready === 1'b1) begin
                done    = 1'b1;
                acc_cnt = int'(bus.q_cnt);
                if (coal && sb.size() > 0) begin
                    e     = sb.pop_back();
                    e.tgt = tgt;
                    e.tkn = tkn;
                    sb.push_back(e);
                end else begin
                    e.pc  = pc;
                    e.tgt = tgt;
                    e.tkn = tkn;
                    sb.push_back(e);
                end
            end else begin
                refused++;
            end
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: pc %0h never accepted", pc);
        end
    endtask

    task automatic drain(input string name);
        bus.lookup_req = 1'b0;
        for (int k = 0; k < 40 && bus.q_cnt != '0; k++) begin
            tick();
        end
        chk({name, "_cnt"}, 64'(bus.q_cnt), 64'd0);
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every table write must match the oldest outstanding update.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] epc;
        if (!rst && bus.tbl_we === 1'b1) begin
            nwr++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got pc %0h required no write", bus.tbl_pc);
            end else begin
                e   = sb.pop_front();
                epc = e.pc;
                chk("wr_pc",  bus.tbl_pc, e.pc);
                chk("wr_tgt", bus.tbl_target, e.tgt);
                chk("wr_tkn", 64'(bus.tbl_taken), 64'(e.tkn));
                chk("wr_idx", 64'(bus.tbl_idx), 64'(epc[BP_SIZE+1:2]));
                chk("wr_gnt", 64'(bus.lookup_gnt), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ref_n;
        int   acc_n;
        int   w0;
        logic coal;
        int   exp_cnt;

        bus.lookup_req  = 1'b1;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = '0;
        bus.upd_target  = '0;
        bus.upd_taken   = 1'b0;
        bus.upd_mispred = 1'b0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_gnt",   64'(bus.lookup_gnt), 64'd0);
        chk("rst_ready", 64'(bus.upd_ready),  64'd0);
        chk("rst_we",    64'(bus.tbl_we),     64'd0);
        chk("rst_cnt",   64'(bus.q_cnt),      64'd0);
        chk("rst_pc",    bus.tbl_pc,          64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_gnt", 64'(bus.lookup_gnt), 64'd1);
            chk("idle_we",  64'(bus.tbl_we),     64'd0);
            chk("idle_cnt", 64'(bus.q_cnt),      64'd0);
            tick();
        end

        // Single update, port free: write one cycle after accept
        bus.lookup_req = 1'b0;
        send(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0, ref_n, acc_n);
        @(negedge clk);
        chk("lat1_we",  64'(bus.tbl_we),  64'd1);
        chk("lat1_idx", 64'(bus.tbl_idx), 64'h004);
        chk("lat1_tgt", bus.tbl_target,   64'h8000_0100);
        tick();
        @(negedge clk);
        chk("lat1_cnt", 64'(bus.q_cnt), 64'd0);
        tick();

        // Starvation: 8 denied cycles, then forced write
        bus.lookup_req = 1'b1;
        send(64'h8000_0040, 64'h8000_0400, 1'b0, 1'b0, 1'b0, ref_n, acc_n);
        for (int k = 1; k <= STARVE_MAX; k++) begin
            @(negedge clk);
            chk("starve_we",  64'(bus.tbl_we),     64'd0);
            chk("starve_gnt", 64'(bus.lookup_gnt), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("starve9_we",  64'(bus.tbl_we),     64'd1);
        chk("starve9_gnt", 64'(bus.lookup_gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("starve_after_gnt", 64'(bus.lookup_gnt), 64'd1);
        chk("starve_after_cnt", 64'(bus.q_cnt),      64'd0);
        tick();

        // Mispredict takes the port immediately
        send(64'h8000_0080, 64'h8000_0800, 1'b1, 1'b1, 1'b0, ref_n, acc_n);
        @(negedge clk);
        chk("msp_we",  64'(bus.tbl_we),     64'd1);
        chk("msp_gnt", 64'(bus.lookup_gnt), 64'd0);
        tick();
        @(negedge clk);
        chk("msp_cnt", 64'(bus.q_cnt), 64'd0);
        tick();

        // Fill to full, held 5th update waits for a slot
        for (int i = 0; i < 4; i++) begin
            send(64'h8000_1000 + 64'(i * 64), 64'h9000_0000 + 64'(i), 1'(i & 1), 1'b0, 1'b0,
                 ref_n, acc_n);
        end
        chk("full_cnt",   64'(bus.q_cnt),     64'd4);
        chk("full_ready", 64'(bus.upd_ready), 64'd0);
        chk("full_we",    64'(bus.tbl_we),    64'd1);
        send(64'h8000_1100, 64'h9000_0004, 1'b1, 1'b0, 1'b0, ref_n, acc_n);
        chk("full5_refused", 64'(ref_n), 64'd1);
        chk("full5_acc_cnt", 64'(acc_n), 64'd3);
        drain("full_drain");
        tick();

        // Reset with three queued updates discards them
        bus.lookup_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(64'h8000_2000 + 64'(i * 4), 64'hA000_0000 + 64'(i), 1'b1, 1'b0, 1'b0,
                 ref_n, acc_n);
        end
        chk("rstmid_cnt_before", 64'(bus.q_cnt), 64'd3);
        rst = 1'b1;
        sb.delete();
        w0 = nwr;
        @(negedge clk);
        chk("rstmid_we", 64'(bus.tbl_we), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_cnt", 64'(bus.q_cnt), 64'd0);
        bus.lookup_req = 1'b0;
        repeat (10) tick();
        chk("rstmid_nowrite", 64'(nwr - w0), 64'd0);

        // Same PC twice
`ifdef BP_UPD_COALESCE_EN
        coal    = 1'b1;
        exp_cnt = 1;
`else
        coal    = 1'b0;
        exp_cnt = 2;
`endif
        bus.lookup_req = 1'b1;
        send(64'h8000_0020, 64'h8000_0200, 1'b0, 1'b0, 1'b0, ref_n, acc_n);
        send(64'h8000_0020, 64'h8000_0204, 1'b1, 1'b0, coal, ref_n, acc_n);
        chk("same_pc_cnt", 64'(bus.q_cnt), 64'(exp_cnt));
        drain("same_pc_drain");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
